// File: rtl/fetch_unit_pf.sv
// Fetch stage with in-order imem request/response, credit-limited prefetch FIFO and redirect flush.
// Optional performance counters are compiled in when FETCH_PERF_CNT_EN is defined.
module fetch_unit_pf #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [31:0]     imem_rdata_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            instr_valid_o,
    output logic [31:0]     instr_o,
    output logic [XLEN-1:0] instr_pc_o,
    input  logic            instr_ready_i,
    output logic            fault_o,
    output logic [XLEN-1:0] fault_pc_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     perf_redirect_o,
    output logic [31:0]     perf_starve_o
`endif
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] resp_pc_q, resp_pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   discard_q, discard_d;
    logic [CW-1:0]   count_q, count_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic            fault_q, fault_d;
    logic [XLEN-1:0] fault_pc_q, fault_pc_d;

    logic [31:0]     data_mem [DEPTH];
    logic [XLEN-1:0] pc_mem   [DEPTH];

    logic credit_ok;
    logic gnt;
    logic drop;
    logic push;
    logic pop;

    always_comb begin
        // NOTE: every signal assigned here gets a default first so no latch is inferred.
        credit_ok     = ({1'b0, count_q} + {1'b0, outstanding_q}) < (CW + 1)'(DEPTH);
        imem_req_o    = !rst_i && !redirect_i && !fault_q && credit_ok;
        imem_addr_o   = fetch_pc_q;
        gnt           = imem_req_o && imem_gnt_i;
        drop          = imem_rvalid_i && (discard_q != '0);
        push          = imem_rvalid_i && !drop && !redirect_i;
        pop           = (count_q != '0) && instr_ready_i && !redirect_i;

        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        fault_d       = fault_q;
        fault_pc_d    = fault_pc_q;
        outstanding_d = outstanding_q + CW'(gnt) - CW'(imem_rvalid_i);
        count_d       = count_q + CW'(push) - CW'(pop);
        discard_d     = drop ? discard_q - CW'(1) : discard_q;

        if (gnt)
            fetch_pc_d = fetch_pc_q + XLEN'(4);
        if (push) begin
            resp_pc_d = resp_pc_q + XLEN'(4);
            wr_ptr_d  = wr_ptr_q + AW'(1);
        end
        if (pop)
            rd_ptr_d = rd_ptr_q + AW'(1);

        // Everything still in flight after this cycle belongs to the old path.
        if (redirect_i) begin
            fetch_pc_d = redirect_pc_i;
            resp_pc_d  = redirect_pc_i;
            discard_d  = outstanding_d;
            count_d    = '0;
            wr_ptr_d   = rd_ptr_q;
            fault_d    = (redirect_pc_i[1:0] != 2'b00);
            if (redirect_pc_i[1:0] != 2'b00)
                fault_pc_d = redirect_pc_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst_i) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            fault_q       <= 1'b0;
            fault_pc_q    <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            count_q       <= count_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            fault_q       <= fault_d;
            fault_pc_q    <= fault_pc_d;
        end
    end

    // NOTE: FIFO storage is not reset; the head is masked whenever the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (push) begin
            data_mem[wr_ptr_q] <= imem_rdata_i;
            pc_mem[wr_ptr_q]   <= resp_pc_q;
        end
    end

    assign instr_valid_o = (count_q != '0);
    assign instr_o       = instr_valid_o ? data_mem[rd_ptr_q] : '0;
    assign instr_pc_o    = instr_valid_o ? pc_mem[rd_ptr_q] : '0;
    assign fault_o       = fault_q;
    assign fault_pc_o    = fault_pc_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_redirect_q, perf_redirect_d;
    logic [31:0] perf_starve_q, perf_starve_d;

    always_comb begin
        perf_redirect_d = perf_redirect_q;
        perf_starve_d   = perf_starve_q;
        if (redirect_i && (perf_redirect_q != '1))
            perf_redirect_d = perf_redirect_q + 32'd1;
        if (instr_ready_i && !instr_valid_o && (perf_starve_q != '1))
            perf_starve_d = perf_starve_q + 32'd1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_redirect_q <= '0;
            perf_starve_q   <= '0;
        end else begin
            perf_redirect_q <= perf_redirect_d;
            perf_starve_q   <= perf_starve_d;
        end
    end

    assign perf_redirect_o = perf_redirect_q;
    assign perf_starve_o   = perf_starve_q;
`endif

    a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(push && !pop && (count_q == CW'(DEPTH))));
    a_discard_bound: assert property (@(posedge clk_i) disable iff (rst_i)
        discard_q <= CW'(DEPTH));

endmodule

// File: tb/tb_fetch_unit_pf.sv
// Scoreboard bench for fetch_unit_pf: a tagged memory model feeds an expected-instruction queue.
// Performance counter checks compile in when FETCH_PERF_CNT_EN is defined.
module tb_fetch_unit_pf;

    localparam int DEPTH = 4;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_ready_i = 1'b0;
    logic        fault_o;
    logic [31:0] fault_pc_o;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_redirect_o;
    logic [31:0] perf_starve_o;
`endif

    fetch_unit_pf #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .instr_valid_o (instr_valid_o),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .instr_ready_i (instr_ready_i),
        .fault_o       (fault_o),
        .fault_pc_o    (fault_pc_o)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_redirect_o (perf_redirect_o),
        .perf_starve_o   (perf_starve_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int          tag;
        logic [31:0] addr;
    } req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    req_t        pend_q[$];
    exp_t        exp_q[$];
    int          epoch = 0;
    logic [31:0] pc_m = 32'h0;
    logic        fault_m = 1'b0;
    logic [31:0] fault_pc_m = 32'h0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          first_gnt_cyc = -1;
    int          first_valid_cyc = -1;
    int          gnt_count = 0;
    int          redirect_m = 0;
    int          starve_m = 0;
    bit          wrap_pending = 1'b0;
    bit          wrap_seen = 1'b0;

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock: drive inputs, compare at the negedge, update the model, advance past posedge.
    task automatic step(input bit g, input bit ren, input bit rdy, input bit rd, input logic [31:0] tgt);
        bit   req_exp;
        bit   grant;
        req_t p;
        imem_gnt_i    = g;
        imem_rvalid_i = ren && (pend_q.size() != 0);
        imem_rdata_i  = imem_rvalid_i ? data_of(pend_q[0].addr) : 32'h0;
        instr_ready_i = rdy;
        redirect_i    = rd;
        redirect_pc_i = tgt;
        @(negedge clk_i);

        req_exp = !rd && !fault_m && ((exp_q.size() + pend_q.size()) < DEPTH);
        check("imem_req", 64'(imem_req_o), 64'(req_exp));
        if (req_exp)
            check("imem_addr", 64'(imem_addr_o), 64'(pc_m));
        check("instr_valid", 64'(instr_valid_o), 64'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            check("instr_pc", 64'(instr_pc_o), 64'(exp_q[0].pc));
            check("instr_data", 64'(instr_o), 64'(exp_q[0].data));
        end
        check("fault", 64'(fault_o), 64'(fault_m));
        check("fault_pc", 64'(fault_pc_o), 64'(fault_pc_m));
        if (instr_valid_o && first_valid_cyc < 0)
            first_valid_cyc = cyc;
        if (rdy && exp_q.size() == 0)
            starve_m++;

        grant = req_exp && g;
        if (rdy && !rd && exp_q.size() != 0)
            void'(exp_q.pop_front());
        if (imem_rvalid_i) begin
            p = pend_q.pop_front();
            if (p.tag == epoch && !rd)
                exp_q.push_back('{pc: p.addr, data: data_of(p.addr)});
        end
        if (grant) begin
            if (first_gnt_cyc < 0)
                first_gnt_cyc = cyc;
            if (wrap_pending) begin
                check("wrap_addr", 64'(imem_addr_o), 64'h0);
                wrap_pending = 1'b0;
                wrap_seen    = 1'b1;
            end
            if (pc_m == 32'hFFFF_FFFC)
                wrap_pending = 1'b1;
            gnt_count++;
            pend_q.push_back('{tag: epoch, addr: pc_m});
            pc_m = pc_m + 32'd4;
        end
        if (rd) begin
            epoch++;
            exp_q.delete();
            pc_m    = tgt;
            fault_m = (tgt[1:0] != 2'b00);
            if (fault_m)
                fault_pc_m = tgt;
            redirect_m++;
            wrap_pending = 1'b0;
        end
        cyc++;
        @(posedge clk_i);
        #1;
    endtask

    task automatic run(input int n, input bit g, input bit ren, input bit rdy);
        for (int i = 0; i < n; i++)
            step(g, ren, rdy, 1'b0, 32'h0);
    endtask

    initial begin
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_req", 64'(imem_req_o), 64'h0);
        check("rst_valid", 64'(instr_valid_o), 64'h0);
        check("rst_instr", 64'(instr_o), 64'h0);
        check("rst_pc", 64'(instr_pc_o), 64'h0);
        check("rst_fault", 64'(fault_o), 64'h0);
        check("rst_fault_pc", 64'(fault_pc_o), 64'h0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        // Streaming with a 1-cycle memory and an always-ready decoder.
        run(12, 1'b1, 1'b1, 1'b1);
        check("first_valid_latency", 64'(first_valid_cyc - first_gnt_cyc), 64'd2);

        // Drain, restart at 0 with decode stalled: exactly DEPTH grants.
        run(4, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'h0);
        gnt_count = 0;
        run(10, 1'b1, 1'b1, 1'b0);
        check("stall_grants", 64'(gnt_count), 64'(DEPTH));
        run(12, 1'b1, 1'b1, 1'b1);

        // Three requests in flight, then redirect to 0x100.
        run(4, 1'b0, 1'b1, 1'b1);
        run(3, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'h100);
        run(10, 1'b1, 1'b1, 1'b1);

        // Redirect coinciding with a response and a pop.
        run(4, 1'b0, 1'b1, 1'b1);
        run(3, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'h300);
        run(10, 1'b1, 1'b1, 1'b1);

        // Misaligned target faults, aligned target recovers.
        step(1'b1, 1'b1, 1'b1, 1'b1, 32'h102);
        run(6, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1, 32'h200);
        run(8, 1'b1, 1'b1, 1'b1);

        // PC wrap at the top of the address space.
        step(1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
        run(8, 1'b1, 1'b1, 1'b1);
        check("wrap_seen", 64'(wrap_seen), 64'h1);

        // Randomised traffic with occasional redirects and faults.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] tgt;
            tgt = 32'($urandom_range(0, 1023)) & 32'hFFFF_FFFC;
            if ($urandom_range(0, 9) == 0)
                tgt = tgt | 32'h2;
            step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 1) != 0,
                 $urandom_range(0, 19) == 0, tgt);
        end
        run(8, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1, 32'h40);
        run(8, 1'b1, 1'b1, 1'b1);

`ifdef FETCH_PERF_CNT_EN
        @(negedge clk_i);
        check("perf_redirect", 64'(perf_redirect_o), 64'(redirect_m));
        check("perf_starve", 64'(perf_starve_o), 64'(starve_m));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
